// File: rtl/rc_command_decoder_if.sv
// Bundled serial-in / command-out signals of the RC command decoder.
// Pulses: cmd_valid, frame_err and timeout are single-cycle strobes with no ready/backpressure; direction is level.
interface rc_command_decoder_if;
    logic       rx;
    logic [4:0] direction;
    logic       cmd_valid;
    logic       frame_err;
    logic       timeout;
    logic [2:0] rx_state;

    modport master (
        output rx,
        input  direction, cmd_valid, frame_err, timeout, rx_state
    );

    modport slave (
        input  rx,
        output direction, cmd_valid, frame_err, timeout, rx_state
    );
endinterface

// File: rtl/rc_command_decoder.sv
// UART 8N1 receiver that decodes ASCII drive letters into a one-hot direction code.
// Optional link-loss watchdog forcing STOP is built when RC_CMD_WATCHDOG_EN is defined.
module rc_command_decoder #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 9600,
    parameter int TIMEOUT_MS = 500
) (
    input  logic                 clk_125mhz,
    input  logic                 reset,
    rc_command_decoder_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    localparam logic [4:0] DIR_FORWARD  = 5'b00001;
    localparam logic [4:0] DIR_BACKWARD = 5'b00010;
    localparam logic [4:0] DIR_LEFT     = 5'b00100;
    localparam logic [4:0] DIR_RIGHT    = 5'b01000;
    localparam logic [4:0] DIR_STOP     = 5'b10000;

    logic             rx_meta, rx_sync;
    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [4:0]       dec_dir;
    logic             dec_hit;
    logic             stop_sample, load, bad_stop, wd_fire;
    logic [4:0]       direction_q;
    logic             cmd_valid_q, frame_err_q, timeout_q;

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit recheck rejects short low glitches.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_sync, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_dir = DIR_STOP;
        case (shift_q)
            8'h46, 8'h66: dec_dir = DIR_FORWARD;
            8'h42, 8'h62: dec_dir = DIR_BACKWARD;
            8'h4C, 8'h6C: dec_dir = DIR_LEFT;
            8'h52, 8'h72: dec_dir = DIR_RIGHT;
            8'h53, 8'h73: dec_dir = DIR_STOP;
            default:      dec_hit = 1'b0;
        endcase
    end

    assign stop_sample = (state == ST_STOP) && (clk_cnt == BIT_LAST);
    assign load        = stop_sample && rx_sync && dec_hit;
    assign bad_stop    = stop_sample && !rx_sync;

`ifdef RC_CMD_WATCHDOG_EN
    localparam int TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;

    // Counter parks one past the expiry value so the timeout fires only once.
    always_ff @(posedge clk_125mhz) begin
        if (reset || load) wd_cnt <= '0;
        else if (wd_cnt != WD_SAT) wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_fire = (wd_cnt == WD_LAST) && !load;
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            direction_q <= DIR_STOP;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cmd_valid_q <= load;
            frame_err_q <= bad_stop;
            timeout_q   <= wd_fire;
            if (load)         direction_q <= dec_dir;
            else if (wd_fire) direction_q <= DIR_STOP;
        end
    end

    assign bus.direction = direction_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;
    assign bus.rx_state  = state;
endmodule

// File: tb/tb_rc_command_decoder.sv
// Directed bench for rc_command_decoder at 10 clocks per bit; watchdog tests follow RC_CMD_WATCHDOG_EN.
module tb_rc_command_decoder;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0, n_ferr = 0, n_tout = 0;
    int   t_valid = 0, t_tout = 0;
    bit   saw_start = 1'b0;
    logic [4:0] exp_q[$];

    rc_command_decoder_if bus();

    rc_command_decoder #(
        .CLK_HZ(1_000_000),
        .BAUD(100_000),
        .TIMEOUT_MS(1)
    ) dut (
        .clk_125mhz(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cmd_valid must match the next queued direction.
    always @(negedge clk) begin
        logic [4:0] exp;
        if (bus.cmd_valid === 1'b1) begin
            n_valid++;
            t_valid = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_valid_unexpected: direction=%b, no command pending", bus.direction);
            end else begin
                exp = exp_q.pop_front();
                if (bus.direction !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_direction: got %b, expected %b", bus.direction, exp);
                end
            end
        end
        if (bus.frame_err === 1'b1) n_ferr++;
        if (bus.timeout === 1'b1) begin
            n_tout++;
            t_tout = cyc;
        end
        if ((bus.cmd_valid | bus.frame_err | bus.timeout) === 1'b1) begin
            checks++;
            if ($countones({bus.cmd_valid, bus.frame_err, bus.timeout}) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: cmd_valid=%b frame_err=%b timeout=%b, expected at most one",
                         bus.cmd_valid, bus.frame_err, bus.timeout);
            end
        end
        if (bus.rx_state == 3'd1) saw_start = 1'b1;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_val;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.direction !== 5'b10000) begin
            errors++; $display("FAIL reset_direction: got %b, expected 10000", bus.direction);
        end
        checks++;
        if ({bus.cmd_valid, bus.frame_err, bus.timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b, expected 000", {bus.cmd_valid, bus.frame_err, bus.timeout});
        end
        checks++;
        if (bus.rx_state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d, expected 0", bus.rx_state);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_decode();
        logic [7:0] bytes [10] = '{8'h46, 8'h72, 8'h62, 8'h4C, 8'h73, 8'h66, 8'h52, 8'h6C, 8'h42, 8'h53};
        logic [4:0] dirs  [10] = '{5'b00001, 5'b01000, 5'b00010, 5'b00100, 5'b10000,
                                   5'b00001, 5'b01000, 5'b00100, 5'b00010, 5'b10000};
        int v0;
        for (int i = 0; i < 10; i++) begin
            v0 = n_valid;
            exp_q.push_back(dirs[i]);
            send_byte(bytes[i], 1'b1);
            repeat (3) @(negedge clk);
            checks++;
            if (bus.direction !== dirs[i]) begin
                errors++; $display("FAIL decode_%h: got %b, expected %b", bytes[i], bus.direction, dirs[i]);
            end
            checks++;
            if (n_valid - v0 != 1) begin
                errors++; $display("FAIL decode_pulses_%h: got %0d cmd_valid, expected 1", bytes[i], n_valid - v0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        int f0 = n_ferr;
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b10000);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h53, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (n_valid - v0 != 3) begin
            errors++; $display("FAIL b2b_count: got %0d cmd_valid, expected 3", n_valid - v0);
        end
        checks++;
        if (n_ferr != f0) begin
            errors++; $display("FAIL b2b_frame_err: got %0d frame_err, expected 0", n_ferr - f0);
        end
        checks++;
        if (bus.direction !== 5'b10000) begin
            errors++; $display("FAIL b2b_direction: got %b, expected 10000", bus.direction);
        end
    endtask

    task automatic test_ignore_and_frame_err();
        int v0;
        int f0;
        exp_q.push_back(5'b00100);
        send_byte(8'h6C, 1'b1);
        repeat (3) @(negedge clk);
        v0 = n_valid;
        send_byte(8'h41, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (n_valid != v0 || bus.direction !== 5'b00100) begin
            errors++; $display("FAIL ignore_byte: got %0d pulses dir %b, expected 0 pulses dir 00100",
                               n_valid - v0, bus.direction);
        end
        f0 = n_ferr;
        send_byte(8'h46, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (n_ferr - f0 != 1) begin
            errors++; $display("FAIL frame_err_count: got %0d, expected 1", n_ferr - f0);
        end
        checks++;
        if (n_valid != v0 || bus.direction !== 5'b00100) begin
            errors++; $display("FAIL frame_err_discard: got %0d pulses dir %b, expected 0 pulses dir 00100",
                               n_valid - v0, bus.direction);
        end
        exp_q.push_back(5'b00010);
        send_byte(8'h42, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.direction !== 5'b00010 || n_valid - v0 != 1) begin
            errors++; $display("FAIL after_frame_err: got dir %b pulses %0d, expected 00010 and 1",
                               bus.direction, n_valid - v0);
        end
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        saw_start = 1'b0;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (saw_start !== 1'b1) begin
            errors++; $display("FAIL glitch_start: START seen=%b, expected 1", saw_start);
        end
        checks++;
        if (bus.rx_state !== 3'd0) begin
            errors++; $display("FAIL glitch_idle: state %0d, expected 0", bus.rx_state);
        end
        checks++;
        if (n_valid != v0 || n_ferr != f0 || bus.direction !== 5'b00010) begin
            errors++; $display("FAIL glitch_outputs: valid %0d ferr %0d dir %b, expected 0 0 00010",
                               n_valid - v0, n_ferr - f0, bus.direction);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h46;
        int v0 = n_valid;
        int f0 = n_ferr;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = b[4];
        repeat (5) @(negedge clk);
        reset  = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.direction !== 5'b10000 || bus.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_frame: dir %b cmd_valid %b, expected 10000 0",
                               bus.direction, bus.cmd_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        checks++;
        if (n_valid != v0 || n_ferr != f0 || bus.direction !== 5'b10000) begin
            errors++; $display("FAIL reset_abort: valid %0d ferr %0d dir %b, expected 0 0 10000",
                               n_valid - v0, n_ferr - f0, bus.direction);
        end
    endtask

`ifdef RC_CMD_WATCHDOG_EN
    task automatic test_watchdog();
        int o0 = n_tout;
        int tv;
        int s;
        exp_q.push_back(5'b00001);
        send_byte(8'h46, 1'b1);
        tv = t_valid;
        repeat (1100) @(negedge clk);
        checks++;
        if (n_tout - o0 != 1) begin
            errors++; $display("FAIL wd_pulse: got %0d timeouts, expected 1", n_tout - o0);
        end
        checks++;
        if (t_tout - tv != 1000) begin
            errors++; $display("FAIL wd_delay: got %0d cycles, expected 1000", t_tout - tv);
        end
        checks++;
        if (bus.direction !== 5'b10000) begin
            errors++; $display("FAIL wd_direction: got %b, expected 10000", bus.direction);
        end
        repeat (3000) @(negedge clk);
        checks++;
        if (n_tout - o0 != 1) begin
            errors++; $display("FAIL wd_saturate: got %0d timeouts, expected 1", n_tout - o0);
        end
        s = cyc;
        exp_q.push_back(5'b00001);
        send_byte(8'h46, 1'b1);
        tv = t_valid;
        for (int k = 0; k < 2000 && cyc != s + 1000; k++) @(negedge clk);
        exp_q.push_back(5'b00010);
        send_byte(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (t_valid - tv != 1000) begin
            errors++; $display("FAIL wd_race_align: got %0d cycles, expected 1000", t_valid - tv);
        end
        checks++;
        if (n_tout - o0 != 1 || bus.direction !== 5'b00010) begin
            errors++; $display("FAIL wd_race: timeouts %0d dir %b, expected 1 00010", n_tout - o0, bus.direction);
        end
    endtask
`else
    task automatic test_no_watchdog();
        exp_q.push_back(5'b00001);
        send_byte(8'h46, 1'b1);
        repeat (5000) @(negedge clk);
        checks++;
        if (bus.direction !== 5'b00001) begin
            errors++; $display("FAIL nowd_direction: got %b, expected 00001", bus.direction);
        end
        checks++;
        if (n_tout != 0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL nowd_timeout: got %0d pulses, expected 0", n_tout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_ignore_and_frame_err();
        test_glitch();
        test_reset_mid_frame();
`ifdef RC_CMD_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d commands never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rc_command_decoder.md
# rc_command_decoder

Serial command front end for the drive train. Receives 8N1 UART bytes from the wireless link, decodes single-character ASCII drive commands into the 5-bit one-hot `direction` code consumed by the dual-motor H-bridge driver, and holds the last command. An optional link-loss watchdog forces STOP when commands stop arriving.

## Interface
- `CLK_HZ`, 125_000_000: clock frequency in Hz.
- `BAUD`, 9600: serial bit rate.
- `TIMEOUT_MS`, 500: watchdog period in ms. Only used with the watchdog compiled in.
- `clk_125mhz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous UART line, idle high.
- `direction`  out  5  one-hot command: FORWARD 00001, BACKWARD 00010, LEFT 00100, RIGHT 01000, STOP 10000.
- `cmd_valid`  out  1  one-cycle pulse when `direction` is loaded from a decoded byte.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `timeout`  out  1  one-cycle pulse when the watchdog forces STOP.

## Operation
- Reset values: `direction`=10000, `cmd_valid`=0, `frame_err`=0, `timeout`=0, RX FSM in IDLE, watchdog counter 0.
- `rx` passes through a 2-flop synchronizer before any use. The synchronizer resets to 1.
- CLKS_PER_BIT = CLK_HZ/BAUD, using integer division. HALF = CLKS_PER_BIT/2.
- RX FSM:
  - IDLE: on synchronized `rx`=0, go to START and clear the bit counter.
  - START: after HALF cycles, sample the line. If 0, go to DATA. If 1, it is a glitch: return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into the byte register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: the byte is complete. Go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized `rx`=1, then go to IDLE.
- Decode of a completed byte:
  - 'F'/'f' (0x46/0x66): FORWARD.
  - 'B'/'b' (0x42/0x62): BACKWARD.
  - 'L'/'l' (0x4C/0x6C): LEFT.
  - 'R'/'r' (0x52/0x72): RIGHT.
  - 'S'/'s' (0x53/0x73): STOP.
- Any other byte is ignored: `direction` is unchanged, with no `cmd_valid` and no watchdog restart.
- A valid command reloads `direction` even when the value is unchanged. It always pulses `cmd_valid`.
- `direction` is always exactly one-hot.

## Timing
- Command latency: `direction` and `cmd_valid` update on the clock edge after the stop-bit sample. That is 2 sync cycles plus roughly 9.5 bit times after the start-bit falling edge.
- `cmd_valid`, `frame_err` and `timeout` are each high for exactly one cycle and are mutually exclusive within a cycle.
- Back-to-back bytes with no idle time between the stop bit and the next start bit are received without loss. The FSM is back in IDLE before the next falling edge is sampled.
- Reset asserted mid-frame aborts the frame. No pulses are generated for the aborted byte. Outputs take their reset values on the next edge.
- Watchdog (when compiled in):
  - The counter increments every cycle and clears on each `cmd_valid`.
  - When it reaches TIMEOUT_CYCLES-1, where TIMEOUT_CYCLES = (CLK_HZ/1000)*TIMEOUT_MS, the next edge sets `direction` to STOP and pulses `timeout`.
  - The counter then saturates: no further `timeout` pulses until a new valid command.
  - If a valid command completes in the expiry cycle, the command wins. `direction` takes the decoded value and `timeout` does not pulse.
  - The counter runs in every `direction` state, including STOP.

## Configuration
- `RC_CMD_WATCHDOG_EN` defined: the watchdog counter and `timeout` logic are built as described in Timing.
- `RC_CMD_WATCHDOG_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - `direction` holds its last decoded value indefinitely.
  - `TIMEOUT_MS` is ignored.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10), TIMEOUT_MS=1 (1000 cycles).
- Reset, then send 0x46 ('F') -> `direction`=00001, one `cmd_valid` pulse. Then send 0x72 ('r') -> `direction`=01000.
- Send 0x4C, 0x42, 0x53 back-to-back with no idle time -> `direction` sequence 00100, 00010, 10000, three `cmd_valid` pulses, no `frame_err`.
- Send 0x41 ('A') -> `direction` unchanged, no `cmd_valid`. Send 0x46 with the stop bit driven low -> one `frame_err` pulse, `direction` unchanged. The next good 0x42 decodes to 00010.
- Drive a 3-cycle low glitch on `rx` -> FSM returns to IDLE, no outputs change. Then assert `reset` during bit 4 of a 0x46 frame -> `direction`=10000, no `cmd_valid`.
- With `RC_CMD_WATCHDOG_EN`:
  - Send 'F', then idle -> 1000 cycles after `cmd_valid`, `direction`=10000 with a single `timeout` pulse, and no second pulse over the next 3000 cycles.
  - Time 'B' to complete in the expiry cycle -> `direction`=00010 and no `timeout`.
- Without `RC_CMD_WATCHDOG_EN`: send 'F', then idle 5000 cycles -> `direction` stays 00001 and `timeout` stays 0.
